// File: rtl/pll_sequencer.sv
// PLL bring-up sequencer: pulses PLL RESETB, waits for a stable synchronized lock,
// then releases downstream reset; retries a bounded number of times before faulting.
module pll_sequencer #(
  parameter int PLL_RESET_CYCLES = 4,
  parameter int LOCK_TIMEOUT     = 16,
  parameter int STABLE_CYCLES    = 8,
  parameter int MAX_RETRIES      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam logic [15:0] RST_LAST = 16'(PLL_RESET_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STB_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  loss_q, loss_d;
  logic [1:0]  sync_q;
  logic        lock_s;
  logic        enter;
  logic        pll_resetb_q, pll_resetb_d;
  logic        sys_reset_q, sys_reset_d;
  logic        fault_q, fault_d;

  assign lock_s = sync_q[1];

  // State register, synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= 2'b00;
      state_q      <= ST_RESET_PLL;
      cnt_q        <= 16'd0;
      retry_q      <= 4'd0;
      loss_q       <= 8'd0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      fault_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], pll_lock};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_resetb_q <= pll_resetb_d;
      sys_reset_q  <= sys_reset_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state logic; restart overrides every other transition
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    enter   = 1'b0;
    if (restart) begin
      state_d = ST_RESET_PLL;
      retry_d = 4'd0;
      enter   = 1'b1;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            enter   = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABILIZE;
            enter   = 1'b1;
          end else if (cnt_q == TO_LAST) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == RETRY_MAX) ? ST_FAULT : ST_RESET_PLL;
            enter   = 1'b1;
          end
        end
        ST_STABILIZE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            enter   = 1'b1;
          end else if (cnt_q == STB_LAST) begin
            state_d = ST_RUN;
            retry_d = 4'd0;
            enter   = 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            retry_d = 4'd0;
            state_d = ST_RESET_PLL;
            enter   = 1'b1;
          end
        end
        ST_FAULT: ;
        default: begin
          state_d = ST_RESET_PLL;
          enter   = 1'b1;
        end
      endcase
    end
    cnt_d = enter ? 16'd0 : cnt_q + 16'd1;
  end

  // Outputs decoded from the next state so they register on the transition edge
  always_comb begin
    pll_resetb_d = 1'b0;
    sys_reset_d  = 1'b1;
    fault_d      = 1'b0;
    case (state_d)
      ST_WAIT_LOCK, ST_STABILIZE: pll_resetb_d = 1'b1;
      ST_RUN: begin
        pll_resetb_d = 1'b1;
        sys_reset_d  = 1'b0;
      end
      ST_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  assign pll_resetb      = pll_resetb_q;
  assign sys_reset       = sys_reset_q;
  assign fault           = fault_q;
  assign state           = state_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// Directed bench for pll_sequencer with default parameters; cycle 0 is the
// first cycle after reset deasserts, inputs change and outputs are sampled 1ns after posedge.
module tb_pll_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       restart;
  logic       pll_resetb;
  logic       sys_reset;
  logic       fault;
  logic [2:0] state;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int cyc;
  int n_checks;
  int n_fail;

  pll_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .pll_lock       (pll_lock),
    .restart        (restart),
    .pll_resetb     (pll_resetb),
    .sys_reset      (sys_reset),
    .fault          (fault),
    .state          (state),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) next_cycle();
  endtask

  task automatic do_reset(input string tag);
    reset    = 1'b1;
    pll_lock = 1'b0;
    restart  = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_state"}, 32'(state), 0);
    check_eq({tag, "_rstb"}, 32'(pll_resetb), 0);
    check_eq({tag, "_sysrst"}, 32'(sys_reset), 1);
    check_eq({tag, "_fault"}, 32'(fault), 0);
    check_eq({tag, "_retry"}, 32'(retry_count), 0);
    check_eq({tag, "_loss"}, 32'(lock_loss_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; pll_lock = 1'b0; restart = 1'b0;
    cyc = 0; n_checks = 0; n_fail = 0;
    repeat (2) @(posedge clk);
    #1;

    // Normal bring-up, lock rises at cycle 10
    do_reset("rst0");
    check_eq("up_rstb_c0", 32'(pll_resetb), 0);
    goto(3);  check_eq("up_rstb_c3", 32'(pll_resetb), 0);
              check_eq("up_state_c3", 32'(state), 0);
    goto(4);  check_eq("up_rstb_c4", 32'(pll_resetb), 1);
              check_eq("up_state_c4", 32'(state), 1);
    goto(10); pll_lock = 1'b1;
    goto(12); check_eq("up_state_c12", 32'(state), 1);
    goto(13); check_eq("up_state_c13", 32'(state), 2);
    goto(20); check_eq("up_sysrst_c20", 32'(sys_reset), 1);
    goto(21); check_eq("up_sysrst_c21", 32'(sys_reset), 0);
              check_eq("up_state_c21", 32'(state), 3);
              check_eq("up_retry_c21", 32'(retry_count), 0);
    $display("txn bring-up: RUN at cycle %0d", cyc);

    // 3-cycle lock drop in RUN
    goto(25); pll_lock = 1'b0;
    goto(27); check_eq("loss_state_c27", 32'(state), 3);
              check_eq("loss_sysrst_c27", 32'(sys_reset), 0);
    goto(28); check_eq("loss_state_c28", 32'(state), 0);
              check_eq("loss_sysrst_c28", 32'(sys_reset), 1);
              check_eq("loss_rstb_c28", 32'(pll_resetb), 0);
              check_eq("loss_cnt_c28", 32'(lock_loss_count), 1);
              pll_lock = 1'b1;
    goto(32); check_eq("loss_state_c32", 32'(state), 1);
    goto(33); check_eq("loss_state_c33", 32'(state), 2);
    goto(40); check_eq("loss_state_c40", 32'(state), 2);
    goto(41); check_eq("loss_state_c41", 32'(state), 3);
              check_eq("loss_cnt_c41", 32'(lock_loss_count), 1);
    $display("txn lock loss: relocked at cycle %0d", cyc);

    // Permanent loss from RUN leads to FAULT, then restart
    goto(45);  pll_lock = 1'b0;
    goto(48);  check_eq("flt_state_c48", 32'(state), 0);
               check_eq("flt_loss_c48", 32'(lock_loss_count), 2);
    goto(68);  check_eq("flt_retry_c68", 32'(retry_count), 1);
    goto(88);  check_eq("flt_retry_c88", 32'(retry_count), 2);
    goto(107); check_eq("flt_state_c107", 32'(state), 1);
               check_eq("flt_fault_c107", 32'(fault), 0);
    goto(108); check_eq("flt_state_c108", 32'(state), 4);
               check_eq("flt_fault_c108", 32'(fault), 1);
               check_eq("flt_retry_c108", 32'(retry_count), 3);
               check_eq("flt_loss_c108", 32'(lock_loss_count), 2);
               check_eq("flt_rstb_c108", 32'(pll_resetb), 0);
    goto(110); restart = 1'b1;
    goto(111); restart = 1'b0;
               check_eq("rs_state_c111", 32'(state), 0);
               check_eq("rs_fault_c111", 32'(fault), 0);
               check_eq("rs_retry_c111", 32'(retry_count), 0);
               check_eq("rs_loss_c111", 32'(lock_loss_count), 2);
               pll_lock = 1'b1;
    // restart beats lock detection in WAIT_LOCK
    goto(115); check_eq("pri_state_c115", 32'(state), 1);
               restart = 1'b1;
    goto(116); restart = 1'b0;
               check_eq("pri_state_c116", 32'(state), 0);
    goto(120); check_eq("pri_state_c120", 32'(state), 1);
    goto(129); check_eq("pri_state_c129", 32'(state), 3);
    $display("txn fault/restart: RUN again at cycle %0d", cyc);

    // Reset in RUN clears everything including loss count
    do_reset("rst_run");

    // Lock glitch during STABILIZE
    goto(10); pll_lock = 1'b1;
    goto(15); check_eq("gl_state_c15", 32'(state), 2);
              pll_lock = 1'b0;
    goto(17); pll_lock = 1'b1;
              check_eq("gl_state_c17", 32'(state), 2);
    goto(18); check_eq("gl_state_c18", 32'(state), 1);
    goto(19); check_eq("gl_state_c19", 32'(state), 1);
    goto(20); check_eq("gl_state_c20", 32'(state), 2);
    goto(27); check_eq("gl_state_c27", 32'(state), 2);
              check_eq("gl_sysrst_c27", 32'(sys_reset), 1);
    goto(28); check_eq("gl_state_c28", 32'(state), 3);
              check_eq("gl_sysrst_c28", 32'(sys_reset), 0);
    $display("txn glitch: RUN at cycle %0d", cyc);

    // No lock at all: three attempts then FAULT
    do_reset("rst_nolock");
    goto(19); check_eq("nl_state_c19", 32'(state), 1);
              check_eq("nl_retry_c19", 32'(retry_count), 0);
    goto(20); check_eq("nl_state_c20", 32'(state), 0);
              check_eq("nl_retry_c20", 32'(retry_count), 1);
    goto(40); check_eq("nl_retry_c40", 32'(retry_count), 2);
    goto(59); check_eq("nl_state_c59", 32'(state), 1);
              check_eq("nl_fault_c59", 32'(fault), 0);
    goto(60); check_eq("nl_state_c60", 32'(state), 4);
              check_eq("nl_fault_c60", 32'(fault), 1);
              check_eq("nl_retry_c60", 32'(retry_count), 3);
              check_eq("nl_rstb_c60", 32'(pll_resetb), 0);
    goto(80); check_eq("nl_state_c80", 32'(state), 4);
              check_eq("nl_rstb_c80", 32'(pll_resetb), 0);
    $display("txn no-lock: FAULT held at cycle %0d", cyc);

    // Saturation of lock loss counter
    do_reset("rst_sat");
    pll_lock = 1'b1;
    goto(13); check_eq("sat_state_c13", 32'(state), 3);
    for (int i = 1; i <= 256; i++) begin
      pll_lock = 1'b0;
      repeat (3) next_cycle();
      pll_lock = 1'b1;
      repeat (13) next_cycle();
      check_eq("sat_run", 32'(state), 3);
      if (i == 1)   check_eq("sat_cnt_1", 32'(lock_loss_count), 1);
      if (i == 255) check_eq("sat_cnt_255", 32'(lock_loss_count), 255);
    end
    check_eq("sat_cnt_256", 32'(lock_loss_count), 255);
    $display("txn saturation: lock_loss_count=%0d", lock_loss_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
